ehl_ddr_wr_sched: RTL and testbench

Write-data scheduler in the DDR controller's clk_0 domain, directly upstream of the PHY transmit stage. It buffers write data from the controller datapath in a small FIFO. It delays each WRITE command by the programmed write latency, then drives write_ena, data_in and data_mask to the PHY for one full burst per command. It also flags command overlap and data underrun.

---
 rtl/ehl_ddr_wr_sched.sv | 152 +++++++++++++++
 tb/tb_ehl_ddr_wr_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_ddr_wr_sched.sv
// ehl_ddr_wr_sched
// Write-data scheduler in the clk_0 domain, sitting directly in front of the
// PHY transmit stage. Write beats from the controller datapath are held in a
// small FIFO. Each WRITE command travels down a delay line for the programmed
// write latency and then starts one burst of N beats (N=2 for BL4, N=4 for BL8)
// toward the PHY.
//
// Ports:
//   clk_0        controller clock
//   reset        synchronous, active-high reset
//   wl           write latency in clk_0 cycles (0 behaves as 1); static while busy=0 only
//   bl8          1: BL8 (4 beats), 0: BL4 (2 beats); static while busy=0 only
//   wcmd         one-cycle WRITE command pulse
//   wd_valid     write beat offered
//   wd_ready     registered "FIFO not full"
//   wd_data      beat data, [7:0] first half, [15:8] second half
//   wd_mask      beat mask, 1 = masked
//   err_clr      clears the sticky error flags
//   write_ena    PHY: write beat valid this cycle
//   data_in      PHY: beat data
//   data_mask    PHY: beat mask (2'b11 when idle or on underrun)
//   busy         a command is in flight or a burst is active
//   err_overlap  sticky: a command was dropped because it overlapped a burst
//   err_underrun sticky: a beat was due while the FIFO was empty
//
// Handshake: a beat transfers on every rising clk_0 edge where wd_valid and
// wd_ready are both 1; wd_valid may be raised independently of wd_ready, and
// the offered beat must stay stable until it transfers.
module ehl_ddr_wr_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int WL_MAX     = 15
) (
  input  logic        clk_0,
  input  logic        reset,
  input  logic [3:0]  wl,
  input  logic        bl8,
  input  logic        wcmd,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [15:0] wd_data,
  input  logic [1:0]  wd_mask,
  input  logic        err_clr,
  output logic        write_ena,
  output logic [15:0] data_in,
  output logic [1:0]  data_mask,
  output logic        busy,
  output logic        err_overlap,
  output logic        err_underrun
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]      TAP_MAX = 4'(WL_MAX - 1);

  logic [17:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;

  logic [WL_MAX-1:0] dl;
  logic [WL_MAX-1:0] dl_next;
  logic [WL_MAX-1:0] win;
  logic [3:0]        tap;
  logic [2:0]        cnt;
  logic [2:0]        cnt_next;
  logic [2:0]        n_beats;
  logic              mature;
  logic              accept;
  logic              overlap;
  logic              beat;
  logic              empty;
  logic              push;
  logic              pop;
  logic              underrun;

  // Delay-line tap: a command entering at bit 0 reaches bit wl-1 one cycle
  // before the edge that must raise write_ena, so the counter loads on time.
  always_comb begin
    tap = 4'd0;
    if (wl > 4'd1) tap = wl - 4'd1;
    if (tap > TAP_MAX) tap = TAP_MAX;
    for (int i = 0; i < WL_MAX; i++) begin
      win[i] = (4'(i) <= tap);
    end
  end

  always_comb begin
    // Bits shifted past the tap are discarded so a later, longer wl can never
    // resurrect an old command.
    dl_next  = {dl[WL_MAX-2:0], wcmd} & win;
    mature   = dl[tap];
    n_beats  = bl8 ? 3'd4 : 3'd2;
    // A maturing command may start only when at most the final beat of the
    // current burst remains; that is what makes back-to-back bursts seamless.
    accept   = mature && (cnt <= 3'd1);
    overlap  = mature && (cnt > 3'd1);
    if (accept)           cnt_next = n_beats;
    else if (cnt != 3'd0) cnt_next = cnt - 3'd1;
    else                  cnt_next = 3'd0;
    // beat: the coming edge launches a write beat toward the PHY.
    beat       = (cnt_next != 3'd0);
    empty      = (count == '0);
    push       = wd_valid && wd_ready;
    pop        = beat && !empty;
    underrun   = beat && empty;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_0) begin
    if (push) mem[wr_ptr] <= {wd_mask, wd_data};
  end

  always_ff @(posedge clk_0) begin
    if (reset) begin
      dl           <= '0;
      cnt          <= 3'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wd_ready     <= 1'b0;
      write_ena    <= 1'b0;
      data_in      <= 16'h0000;
      data_mask    <= 2'b11;
      busy         <= 1'b0;
      err_overlap  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      dl        <= dl_next;
      cnt       <= cnt_next;
      count     <= count_next;
      wd_ready  <= (count_next != DEPTH_C);
      write_ena <= beat;
      busy      <= (|dl_next) || beat;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (pop) begin
        data_in   <= mem[rd_ptr][15:0];
        data_mask <= mem[rd_ptr][17:16];
      end else if (underrun) begin
        data_in   <= 16'h0000;
        data_mask <= 2'b11;
      end else begin
        data_mask <= 2'b11;
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      err_overlap  <= overlap  || (err_overlap  && !err_clr);
      err_underrun <= underrun || (err_underrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_ehl_ddr_wr_sched.sv
// tb_ehl_ddr_wr_sched
// Directed scenarios followed by a randomized phase. A reference model works
// on burst intervals (start edge, last-beat edge) and a queue of buffered
// beats; every output is compared after every clock edge.
module tb_ehl_ddr_wr_sched;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic        clk_0 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wl = 4'd1;
  logic        bl8 = 1'b0;
  logic        wcmd = 1'b0;
  logic        wd_valid = 1'b0;
  logic [15:0] wd_data = 16'h0;
  logic [1:0]  wd_mask = 2'b00;
  logic        err_clr = 1'b0;
  logic        wd_ready;
  logic        write_ena;
  logic [15:0] data_in;
  logic [1:0]  data_mask;
  logic        busy;
  logic        err_overlap;
  logic        err_underrun;

  always #5 clk_0 = ~clk_0;

  ehl_ddr_wr_sched #(.FIFO_DEPTH(DEPTH), .WL_MAX(15)) dut (
    .clk_0(clk_0), .reset(reset), .wl(wl), .bl8(bl8), .wcmd(wcmd),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .wd_mask(wd_mask), .err_clr(err_clr), .write_ena(write_ena),
    .data_in(data_in), .data_mask(data_mask), .busy(busy),
    .err_overlap(err_overlap), .err_underrun(err_underrun)
  );

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  logic [17:0] exp_q[$];     // buffered beats {mask, data}
  int          pend_q[$];    // edge at which each in-flight command matures
  int          cur_start = -100;
  int          last_beat = -100;
  logic        m_wena = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic [1:0]  m_mask = 2'b11;
  logic        m_ready = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ovl = 1'b0;
  logic        m_und = 1'b0;

  task automatic model_edge();
    int          t;
    int          n;
    int          wle;
    logic        bt;
    logic        ovl_set;
    logic        und_set;
    logic [17:0] h;
    t = edge_no;
    ovl_set = 1'b0;
    und_set = 1'b0;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      cur_start = -100;
      last_beat = -100;
      m_wena = 1'b0; m_data = 16'h0; m_mask = 2'b11;
      m_ready = 1'b0; m_busy = 1'b0; m_ovl = 1'b0; m_und = 1'b0;
      return;
    end
    n = bl8 ? 4 : 2;
    while (pend_q.size() > 0 && pend_q[0] == t) begin
      void'(pend_q.pop_front());
      if (t > last_beat) begin
        cur_start = t;
        last_beat = t + n - 1;
      end else begin
        ovl_set = 1'b1;
      end
    end
    bt = (t >= cur_start) && (t <= last_beat);
    if (bt) begin
      if (exp_q.size() > 0) begin
        h = exp_q.pop_front();
        m_data = h[15:0];
        m_mask = h[17:16];
      end else begin
        m_data = 16'h0;
        m_mask = 2'b11;
        und_set = 1'b1;
      end
    end else begin
      m_mask = 2'b11;
    end
    if (wd_valid && m_ready) exp_q.push_back({wd_mask, wd_data});
    if (wcmd) begin
      wle = (wl == 4'd0) ? 1 : int'(wl);
      pend_q.push_back(t + wle);
    end
    m_ovl   = ovl_set || (m_ovl && !err_clr);
    m_und   = und_set || (m_und && !err_clr);
    m_ready = (exp_q.size() != DEPTH);
    m_busy  = bt || (pend_q.size() > 0);
    m_wena  = bt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("write_ena",    32'(write_ena),    32'(m_wena));
    check("data_in",      32'(data_in),      32'(m_data));
    check("data_mask",    32'(data_mask),    32'(m_mask));
    check("wd_ready",     32'(wd_ready),     32'(m_ready));
    check("busy",         32'(busy),         32'(m_busy));
    check("err_overlap",  32'(err_overlap),  32'(m_ovl));
    check("err_underrun", 32'(err_underrun), 32'(m_und));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_0);
    model_edge();
    #1;
    check_outputs();
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_beat(input logic [15:0] d, input logic [1:0] m);
    wd_valid = 1'b1; wd_data = d; wd_mask = m;
    step();
    wd_valid = 1'b0;
  endtask

  task automatic cmd();
    wcmd = 1'b1;
    step();
    wcmd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    reset = 1'b1; wl = 4'd5; bl8 = 1'b0;
    idle(2);
    check("rst_wena",  32'(write_ena), 32'd0);
    check("rst_mask",  32'(data_mask), 32'd3);
    check("rst_data",  32'(data_in),   32'd0);
    check("rst_ready", 32'(wd_ready),  32'd0);
    reset = 1'b0;
    step();
    check("ready_after_rst", 32'(wd_ready), 32'd1);

    // Scenario 1: wl=5, BL4
    push_beat(16'h1111, 2'b00);
    push_beat(16'h2222, 2'b00);
    cmd();                           // edge T
    idle(4);                         // T+1..T+4
    check("s1_busy_wait", 32'(busy), 32'd1);
    step();                          // T+5
    check("s1_beat0", 32'(data_in), 32'h1111);
    check("s1_mask0", 32'(data_mask), 32'd0);
    step();                          // T+6
    check("s1_beat1", 32'(data_in), 32'h2222);
    step();                          // T+7
    check("s1_done_wena", 32'(write_ena), 32'd0);
    check("s1_done_busy", 32'(busy), 32'd0);
    idle(2);

    // Scenario 2: wl=3, BL8, seamless pair
    wl = 4'd3; bl8 = 1'b1;
    for (int i = 0; i < 8; i++) push_beat(16'($urandom), 2'($urandom_range(0, 3)));
    cmd();
    idle(3);
    cmd();
    idle(10);
    check("s2_no_overlap", 32'(err_overlap), 32'd0);

    // Scenario 3: overlapping command is dropped
    for (int i = 0; i < 4; i++) push_beat(16'h3000 + 16'(i), 2'b01);
    cmd();
    idle(1);
    cmd();
    idle(10);
    check("s3_overlap", 32'(err_overlap), 32'd1);
    check("s3_wena_end", 32'(write_ena), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("s3_cleared", 32'(err_overlap), 32'd0);

    // Scenario 4: fill the FIFO, ninth beat waits for a pop
    wl = 4'd2; bl8 = 1'b1;
    for (int i = 0; i < 8; i++) push_beat(16'h4000 + 16'(i), 2'b00);
    wd_valid = 1'b1; wd_data = 16'h4008; wd_mask = 2'b10;
    idle(3);
    check("s4_full", 32'(wd_ready), 32'd0);
    cmd();                           // T
    step();                          // T+1
    step();                          // T+2: first pop
    check("s4_freed", 32'(wd_ready), 32'd1);
    step();                          // T+3: ninth beat accepted
    wd_valid = 1'b0;
    cmd();                           // T+4
    idle(8);

    // Scenario 5: one beat buffered, BL4 -> underrun on second beat
    wl = 4'd2; bl8 = 1'b0;
    cmd();                           // T
    step();                          // T+1
    step();                          // T+2
    check("s5_beat0", 32'(data_in), 32'h4008);
    step();                          // T+3
    check("s5_und_data", 32'(data_in), 32'd0);
    check("s5_und_mask", 32'(data_mask), 32'd3);
    check("s5_und_flag", 32'(err_underrun), 32'd1);
    idle(3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Scenario 6: reset truncates a BL8 burst
    wl = 4'd3; bl8 = 1'b1;
    for (int i = 0; i < 4; i++) push_beat(16'h6000 + 16'(i), 2'b00);
    cmd();
    idle(4);                         // beats 1 and 2 issued
    reset = 1'b1; wcmd = 1'b1;
    step();
    wcmd = 1'b0;
    check("s6_wena", 32'(write_ena), 32'd0);
    check("s6_mask", 32'(data_mask), 32'd3);
    check("s6_ready", 32'(wd_ready), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wl = 4'd5; bl8 = 1'b0;
    step();
    push_beat(16'hAAAA, 2'b00);
    push_beat(16'h5555, 2'b00);
    cmd();
    idle(5);
    check("s6_fresh0", 32'(data_in), 32'hAAAA);
    step();
    check("s6_fresh1", 32'(data_in), 32'h5555);
    idle(3);

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      if (!m_busy && $urandom_range(0, 7) == 0) begin
        wl  = 4'($urandom_range(0, 6));
        bl8 = 1'($urandom_range(0, 1));
      end
      wd_valid = 1'($urandom_range(0, 1));
      wd_data  = 16'($urandom);
      wd_mask  = 2'($urandom_range(0, 3));
      wcmd     = ($urandom_range(0, 4) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    wd_valid = 1'b0; wcmd = 1'b0; err_clr = 1'b0;
    idle(20);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
